serial_chunk_adder: RTL and testbench
=====================================

Name: serial_chunk_adder

Overview:
- Parametrised, multi-cycle successor to the team's fixed 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks through a registered carry.
- Uses valid/ready handshakes on both input and output, so it drops into streaming datapaths and trades latency for a short carry chain.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock (ripple width per cycle); 1 <= CHUNK <= WIDTH; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/cin presented
- in_ready  output  1  block can accept operands this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result this cycle
- sum  output  WIDTH  result, A+B+cin mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high, and named rst.
- Reset values (while rst is high): state=IDLE, chunk index=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=0.
- FSM states: IDLE, ADD, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready to in_ready.
- Accept occurs on a rising edge with in_valid && in_ready:
  - latch in1, in2 into operand registers; carry reg <= cin; index <= 0; state <= ADD.
  - Inputs are sampled only on accept and are ignored at all other times.
- ADD, one chunk per cycle, i = index:
  - {c, s} = A[i*CHUNK +: CHUNK] + B[i*CHUNK +: CHUNK] + carry.
  - sum[i*CHUNK +: CHUNK] <= s; carry <= c.
  - If i == NCHUNK-1: cout <= c; ovf <= (A[MSB]==B[MSB]) && (s[CHUNK-1] != A[MSB]); state <= DONE. Otherwise index <= i+1.
- DONE: out_valid=1. sum, cout and ovf hold stable until the handshake.
  - out_ready=1 with no new accept: state <= IDLE, out_valid <= 0.
  - out_ready=1 with in_valid=1: new operands are accepted on the same edge and the FSM goes directly to ADD (back-to-back).
- Latency: out_valid rises exactly NCHUNK clocks after the accept edge.
- Throughput: one result per NCHUNK+1 cycles when back-to-back.
- NCHUNK==1: ADD lasts one cycle; the same rules apply.
- sum/cout/ovf are undefined for checking while out_valid=0. sum may change chunk-wise during ADD; sum holds the previous result only in IDLE.
- Reset asserted mid-ADD or in DONE abandons the operation immediately. No result is produced, and the next accept after reset behaves normally.
- Boundary cases:
  - All-ones + 1 wraps to 0 with cout=1.
  - Carry must propagate across every chunk boundary.
  - cin=1 with both operands all-ones gives sum = all-ones, cout=1.

Optional Feature:
- Macro: SERIAL_CHUNK_ADDER_SUBTRACT_EN.
- When defined:
  - Extra input port sub (1 bit), latched on accept.
  - If sub=1: operand B register <= ~in2 and carry reg <= 1; cin is ignored. The result is A-B, cout=1 means no borrow, and ovf is computed with the inverted B MSB.
  - sub=0 behaves exactly as plain add.
- When undefined: no sub port, adder only, and the logic is identical to sub=0.

Test Plan:
- Reset: hold rst 3 cycles, then release → all outputs 0 during reset; in_ready=1 on the first cycle after release, out_valid=0.
- WIDTH=16, CHUNK=4: 0x1234 + 0x4321, cin=0 → out_valid exactly 4 clocks after accept; sum=0x5555, cout=0, ovf=0.
- Carry/overflow: 0xFFFF+0x0001 cin=0 → sum=0x0000, cout=1, ovf=0. 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1. 0xFFFF+0xFFFF cin=1 → 0xFFFF, cout=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → sum/cout/ovf stable, in_ready=0.
  - Then assert out_ready=1 and in_valid=1 together with 0x0001+0x0002 → accepted that edge; next result 0x0003 appears 4 clocks later.
- Reset mid-op: accept 0xAAAA+0x5555, assert rst after 2 ADD cycles → out_valid never rises. Next op 0x0100+0x00FF gives 0x01FF.
- With SERIAL_CHUNK_ADDER_SUBTRACT_EN:
  - 0x0005-0x0007 → 0xFFFE, cout=0.
  - 0x8000-0x0001 → 0x7FFF, cout=1, ovf=1.
  - Also run the NCHUNK=1 config (CHUNK=16) → result 1 clock after accept.

Source files
------------

// File: rtl/serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// serial_chunk_adder
//   Multi-cycle adder. It adds two WIDTH-bit operands CHUNK bits per clock and
//   passes the carry between chunks through a register. Valid/ready handshakes
//   sit on both sides. It also reports the carry-out and the two's-complement
//   signed overflow.
//
// Parameters:
//   WIDTH  operand/sum width (must be a multiple of CHUNK)
//   CHUNK  bits added per clock; NCHUNK = WIDTH/CHUNK cycles per operation
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands/cin presented
//   in_ready   operands accepted this cycle (combinational from out_ready)
//   in1, in2   operands A and B
//   cin        carry-in
//   sub        (only with SERIAL_CHUNK_ADDER_SUBTRACT_EN) 1 = compute A-B
//   out_valid  result available
//   out_ready  consumer takes the result this cycle
//   sum        A+B+cin mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        two's-complement signed overflow
//
// Optional feature macro: SERIAL_CHUNK_ADDER_SUBTRACT_EN
// -----------------------------------------------------------------------------
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             last_s;
  logic             ovf_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   chunk_sum_s;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;

  // Operand B and initial carry as loaded on accept (subtract inverts B, forces carry 1)
  always_comb begin
    b_load_s     = in2;
    carry_load_s = cin;
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
    if (sub) begin
      b_load_s     = ~in2;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = in2;
      carry_load_s = cin;
    end
`endif
  end

  // Handshake and one-chunk ripple add for the current index
  always_comb begin
    // in_ready is held low during reset so nothing is taken while rst is high
    in_ready_s  = !rst && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
    accept_s    = in_valid && in_ready_s;
    last_s      = (idx_r == LAST_IDX);
    a_chunk_s   = a_r[32'(idx_r) * CHUNK +: CHUNK];
    b_chunk_s   = b_r[32'(idx_r) * CHUNK +: CHUNK];
    chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    // Overflow: operands agree in sign but the result sign differs
    ovf_s       = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                  (chunk_sum_s[CHUNK-1] != a_r[WIDTH-1]);
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = ADD;
        else          state_nxt_s = IDLE;
      end
      ADD: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = ADD;
      end
      DONE: begin
        if (accept_s)       state_nxt_s = ADD;
        else if (out_ready) state_nxt_s = IDLE;
        else                state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand, carry, index and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      idx_r       <= {IW{1'b0}};
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        a_r     <= in1;
        b_r     <= b_load_s;
        carry_r <= carry_load_s;
        idx_r   <= {IW{1'b0}};
      end else if (state_r == ADD) begin
        sum_r[32'(idx_r) * CHUNK +: CHUNK] <= chunk_sum_s[CHUNK-1:0];
        carry_r <= chunk_sum_s[CHUNK];
        if (last_s) begin
          cout_r <= chunk_sum_s[CHUNK];
          ovf_r  <= ovf_s;
        end else begin
          idx_r <= idx_r + IW'(1);
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_chunk_adder.sv
module tb_serial_chunk_adder;

  logic        clk;
  logic        rst;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        cin;
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
  logic        sub;
`endif
  logic        out_ready;
  logic        in_valid0, in_ready0, out_valid0, cout0, ovf0;
  logic        in_valid1, in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] sum0, sum1;

  int checks   = 0;
  int failures = 0;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in1(in1), .in2(in2), .cin(cin),
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
    .sub(sub),
`endif
    .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in1(in1), .in2(in2), .cin(cin),
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
    .sub(sub),
`endif
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation to DUT 'dut' (0: CHUNK=4, 1: CHUNK=16) while it is idle,
  // then count clocks from the accept edge until out_valid (bounded at 20).
  task automatic run_op(input int dut, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, output int lat);
    in1 = a; in2 = b; cin = c;
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
    sub = s;
`else
    if (s) $display("note: subtract request ignored in add-only build");
`endif
    if (dut == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    lat = 0;
    while (((dut == 0) ? !out_valid0 : !out_valid1) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready0); end
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
    checks++; if ({sum0, cout0, ovf0} !== 18'h0) begin failures++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b exp all 0", sum0, cout0, ovf0); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready0); end
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid0); end
  endtask

  task automatic test_add_basic();
    int lat;
    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (sum0 !== 16'h5555) begin failures++; $display("FAIL basic_sum got=%h exp=5555", sum0); end
    checks++; if ({cout0, ovf0} !== 2'b00) begin failures++; $display("FAIL basic_flags got cout=%b ovf=%b exp 0 0", cout0, ovf0); end
    pop();
  endtask

  task automatic test_carry_ovf();
    logic [15:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h0FFF, 16'h8000};
    logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000};
    logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] es [5] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h1000, 16'h0000};
    logic        eco[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        eov[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(0, ta[i], tb[i], tc[i], 1'b0, lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL carry_latency[%0d] got=%0d exp=4", i, lat); end
      checks++; if (sum0 !== es[i]) begin failures++; $display("FAIL carry_sum[%0d] got=%h exp=%h", i, sum0, es[i]); end
      checks++; if (cout0 !== eco[i]) begin failures++; $display("FAIL carry_cout[%0d] got=%b exp=%b", i, cout0, eco[i]); end
      checks++; if (ovf0 !== eov[i]) begin failures++; $display("FAIL carry_ovf[%0d] got=%b exp=%b", i, ovf0, eov[i]); end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid0, in_ready0, cout0, ovf0, sum0} !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h8000}) begin
        failures++;
        $display("FAIL hold_stable[%0d] got valid=%b ready=%b cout=%b ovf=%b sum=%h exp 1 0 0 1 8000",
                 i, out_valid0, in_ready0, cout0, ovf0, sum0);
      end
    end
    in1 = 16'h0001; in2 = 16'h0002; cin = 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
    sub = 1'b0;
`endif
    out_ready = 1'b1; in_valid0 = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready0); end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid0 = 1'b0;
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b exp=0", out_valid0); end
    lat = 0;
    while (!out_valid0 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    checks++; if (sum0 !== 16'h0003) begin failures++; $display("FAIL b2b_sum got=%h exp=0003", sum0); end
    checks++; if ({cout0, ovf0} !== 2'b00) begin failures++; $display("FAIL b2b_flags got cout=%b ovf=%b exp 0 0", cout0, ovf0); end
    pop();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic seen;
    in1 = 16'hAAAA; in2 = 16'h5555; cin = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({out_valid0, in_ready0} !== 2'b00) begin failures++; $display("FAIL midop_reset got valid=%b ready=%b exp 0 0", out_valid0, in_ready0); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid0;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midop_no_result got=%b exp=0", seen); end
    run_op(0, 16'h0100, 16'h00FF, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL after_reset_latency got=%0d exp=4", lat); end
    checks++; if (sum0 !== 16'h01FF) begin failures++; $display("FAIL after_reset_sum got=%h exp=01FF", sum0); end
    pop();
  endtask

  task automatic test_nchunk1();
    int lat;
    run_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL n1_latency got=%0d exp=1", lat); end
    checks++; if (sum1 !== 16'h5555) begin failures++; $display("FAIL n1_sum got=%h exp=5555", sum1); end
    pop();
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++; if ({sum1, cout1, ovf1} !== {16'h0000, 1'b1, 1'b0}) begin failures++; $display("FAIL n1_wrap got sum=%h cout=%b ovf=%b exp 0000 1 0", sum1, cout1, ovf1); end
    pop();
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++; if ({sum1, cout1, ovf1} !== {16'h8000, 1'b0, 1'b1}) begin failures++; $display("FAIL n1_ovf got sum=%h cout=%b ovf=%b exp 8000 0 1", sum1, cout1, ovf1); end
    pop();
  endtask

`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
  task automatic test_subtract();
    int lat;
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL sub_latency got=%0d exp=4", lat); end
    checks++; if ({sum0, cout0, ovf0} !== {16'hFFFE, 1'b0, 1'b0}) begin failures++; $display("FAIL sub_neg got sum=%h cout=%b ovf=%b exp FFFE 0 0", sum0, cout0, ovf0); end
    pop();
    // cin=1 must be ignored while subtracting
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, lat);
    checks++; if ({sum0, cout0, ovf0} !== {16'h7FFF, 1'b1, 1'b1}) begin failures++; $display("FAIL sub_ovf got sum=%h cout=%b ovf=%b exp 7FFF 1 1", sum0, cout0, ovf0); end
    pop();
    run_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    checks++; if ({lat, sum1, cout1} !== {32'd1, 16'hFFFE, 1'b0}) begin failures++; $display("FAIL n1_sub got lat=%0d sum=%h cout=%b exp 1 FFFE 0", lat, sum1, cout1); end
    pop();
  endtask
`endif

  initial begin
    rst = 1'b1; in1 = 16'h0; in2 = 16'h0; cin = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
    sub = 1'b0;
`endif
    test_reset();
    test_add_basic();
    test_carry_ovf();
    test_back_to_back();
    test_reset_midop();
    test_nchunk1();
`ifdef SERIAL_CHUNK_ADDER_SUBTRACT_EN
    test_subtract();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
